// File: rtl/vga_digit_row_overlay_if.sv
// Font ROM bus between the digit-row overlay (master) and an external
// registered 8x16 font ROM (slave): rom_data follows rom_addr by one clock.
interface vga_digit_row_overlay_if;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/vga_digit_row_overlay.sv
// Draws one text row of NGRP two-digit BCD groups with separators, using frame-
// synchronous shadow copies of the values, edit blinking and an alarm flash.
module vga_digit_row_overlay #(
  parameter int         NGRP         = 3,
  parameter int         X0           = 192,
  parameter int         Y0           = 128,
  parameter int         SCALE        = 2,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] FG_RGB       = 3'b111,
  parameter logic [2:0] EDIT_RGB     = 3'b100,
  parameter logic [2:0] ALARM_RGB    = 3'b100
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             pix_x,
  input  logic [9:0]             pix_y,
  input  logic                   frame_tick,
  input  logic [8*NGRP-1:0]      digits,
  input  logic [6:0]             sep_char,
  input  logic [NGRP-1:0]        edit_sel,
  input  logic                   alarm,
  vga_digit_row_overlay_if.master font,
  output logic                   text_on,
  output logic [2:0]             text_rgb
);

  localparam int NCHAR  = 3*NGRP - 1;
  localparam int CHAR_W = 8 << SCALE;
  localparam int CHAR_H = 16 << SCALE;
  localparam int X1     = X0 + NCHAR*CHAR_W;
  localparam int Y1     = Y0 + CHAR_H;
  localparam int CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [8*NGRP-1:0] digits_sh_reg;
  logic [6:0]        sep_sh_reg;
  logic [NGRP-1:0]   edit_sh_reg;
  logic              alarm_sh_reg;
  logic [CW-1:0]     blink_cnt_reg;
  logic              blink_phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_sh_reg   <= '0;
      sep_sh_reg      <= '0;
      edit_sh_reg     <= '0;
      alarm_sh_reg    <= 1'b0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (frame_tick) begin
      digits_sh_reg <= digits;
      sep_sh_reg    <= sep_char;
      edit_sh_reg   <= edit_sel;
      alarm_sh_reg  <= alarm;
      if (blink_cnt_reg == CW'(BLINK_FRAMES-1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // Per-character lookup built from the shadow copies; separators are never "edited".
  logic [6:0]       char_lut [NCHAR];
  logic [NCHAR-1:0] edit_lut;

  genvar gi;
  generate
    for (gi = 0; gi < NCHAR; gi++) begin : g_char
      if (gi % 3 == 2) begin : g_sep
        assign char_lut[gi] = sep_sh_reg;
        assign edit_lut[gi] = 1'b0;
      end else begin : g_dig
        localparam int LSB = 8*(gi/3) + ((gi % 3 == 0) ? 4 : 0);
        logic [3:0] nib;
        assign nib          = digits_sh_reg[LSB +: 4];
        assign char_lut[gi] = (nib <= 4'd9) ? {3'b011, nib} : 7'h3f;
        assign edit_lut[gi] = edit_sh_reg[gi/3];
      end
    end
  endgenerate

  // Stage 0: position decode; dx/dy underflow outside the row is masked by in_row.
  logic       in_row;
  logic [9:0] dx, dy, k_full;
  logic [2:0] bit_idx;
  logic [3:0] row_idx;
  logic [6:0] char_sel;
  logic       edit_hit;
  logic [2:0] rgb_next;

  assign in_row  = ({2'b00, pix_x} >= 12'(X0)) && ({2'b00, pix_x} < 12'(X1)) &&
                   ({2'b00, pix_y} >= 12'(Y0)) && ({2'b00, pix_y} < 12'(Y1));
  assign dx      = pix_x - 10'(X0);
  assign dy      = pix_y - 10'(Y0);
  assign k_full  = dx >> (3 + SCALE);
  assign bit_idx = 3'(dx >> SCALE);
  assign row_idx = 4'(dy >> SCALE);

  always_comb begin
    char_sel = '0;
    edit_hit = 1'b0;
    for (int i = 0; i < NCHAR; i++) begin
      if (k_full == 10'(i)) begin
        char_sel = char_lut[i];
        edit_hit = edit_lut[i];
      end
    end
  end

  always_comb begin
    rgb_next = FG_RGB;
    if (edit_hit && !blink_phase_reg)
      rgb_next = 3'b000;
    else if (alarm_sh_reg)
      rgb_next = blink_phase_reg ? ALARM_RGB : FG_RGB;
    else if (edit_hit)
      rgb_next = EDIT_RGB;
  end

  // Stage 1 issues the ROM address; stage 2 lines up with the ROM's own output register.
  logic [10:0] rom_addr_reg;
  logic        in_row_s1, text_on_reg;
  logic [2:0]  bit_s1, bit_s2;
  logic [2:0]  rgb_s1, rgb_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_reg <= '0;
      in_row_s1    <= 1'b0;
      bit_s1       <= '0;
      rgb_s1       <= '0;
      text_on_reg  <= 1'b0;
      bit_s2       <= '0;
      rgb_s2       <= '0;
    end else begin
      rom_addr_reg <= {char_sel, row_idx};
      in_row_s1    <= in_row;
      bit_s1       <= bit_idx;
      rgb_s1       <= rgb_next;
      text_on_reg  <= in_row_s1;
      bit_s2       <= bit_s1;
      rgb_s2       <= rgb_s1;
    end
  end

  assign font.rom_addr = rom_addr_reg;
  assign text_on       = text_on_reg;
  assign text_rgb      = (text_on_reg && font.rom_data[~bit_s2]) ? rgb_s2 : 3'b000;

endmodule

// File: tb/tb_vga_digit_row_overlay.sv
// Directed bench for vga_digit_row_overlay with a small registered font ROM model
// (even glyph rows 8'hAA, odd rows 8'h55).
module tb_vga_digit_row_overlay;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        frame_tick = 1'b0;
  logic [23:0] digits = '0;
  logic [6:0]  sep_char = 7'h3a;
  logic [2:0]  edit_sel = '0;
  logic        alarm = 1'b0;
  logic        text_on;
  logic [2:0]  text_rgb;
  int pass_cnt = 0, total_cnt = 0;

  vga_digit_row_overlay_if font_bus();

  vga_digit_row_overlay dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .frame_tick(frame_tick), .digits(digits), .sep_char(sep_char),
    .edit_sel(edit_sel), .alarm(alarm), .font(font_bus),
    .text_on(text_on), .text_rgb(text_rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    font_bus.rom_data <= font_bus.rom_addr[0] ? 8'h55 : 8'hAA;

  task automatic reset_dut();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic probe(input int x, input int y, output logic [10:0] addr,
                       output logic on, output logic [2:0] rgb);
    @(negedge clk);
    pix_x = 10'(x); pix_y = 10'(y);
    @(posedge clk); #1 addr = font_bus.rom_addr;
    @(posedge clk); #1 on = text_on; rgb = text_rgb;
  endtask

  task automatic test_reset();
    logic [10:0] a; logic o; logic [2:0] c;
    reset_dut();
    digits = 24'h563412; tick();
    probe(192, 128, a, o, c);
    total_cnt++; if (o !== 1'b1) $display("FAIL reset_pre_on: got %b want 1", o); else pass_cnt++;
    @(negedge clk); #2 rst_n = 1'b0; #1;
    total_cnt++; if (text_on !== 1'b0) $display("FAIL reset_async_on: got %b want 0", text_on); else pass_cnt++;
    total_cnt++; if (text_rgb !== 3'b000) $display("FAIL reset_async_rgb: got %b want 000", text_rgb); else pass_cnt++;
    total_cnt++; if (font_bus.rom_addr !== 11'h000) $display("FAIL reset_async_addr: got %h want 000", font_bus.rom_addr); else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    probe(192, 128, a, o, c);
    total_cnt++; if (a !== 11'h300) $display("FAIL reset_shadow_zero: got %h want 300", a); else pass_cnt++;
    total_cnt++; if (o !== 1'b1 || c !== 3'b111) $display("FAIL reset_first_pixel: got on=%b rgb=%b want 1/111", o, c); else pass_cnt++;
  endtask

  task automatic test_render();
    logic [10:0] a; logic o; logic [2:0] c;
    reset_dut();
    digits = 24'h563412; sep_char = 7'h3a; edit_sel = '0; alarm = 1'b0; tick();
    @(negedge clk) pix_x = 10'd0; pix_y = 10'd0;
    repeat (2) @(negedge clk);
    pix_x = 10'd192; pix_y = 10'd128;
    @(posedge clk); #1;
    total_cnt++; if (font_bus.rom_addr !== 11'h310) $display("FAIL render_addr_lat1: got %h want 310", font_bus.rom_addr); else pass_cnt++;
    total_cnt++; if (text_on !== 1'b0) $display("FAIL render_on_lat1: got %b want 0", text_on); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (text_on !== 1'b1 || text_rgb !== 3'b111) $display("FAIL render_lat2: got on=%b rgb=%b want 1/111", text_on, text_rgb); else pass_cnt++;
    probe(256, 128, a, o, c);
    total_cnt++; if (a !== 11'h3a0 || c !== 3'b111) $display("FAIL render_sep: got addr=%h rgb=%b want 3a0/111", a, c); else pass_cnt++;
    probe(288, 128, a, o, c);
    total_cnt++; if (a !== 11'h330) $display("FAIL render_grp1: got %h want 330", a); else pass_cnt++;
    probe(416, 128, a, o, c);
    total_cnt++; if (a !== 11'h360) $display("FAIL render_last_char: got %h want 360", a); else pass_cnt++;
    probe(447, 128, a, o, c);
    total_cnt++; if (o !== 1'b1 || c !== 3'b000) $display("FAIL render_x447: got on=%b rgb=%b want 1/000", o, c); else pass_cnt++;
    probe(448, 128, a, o, c);
    total_cnt++; if (o !== 1'b0 || c !== 3'b000) $display("FAIL render_x448: got on=%b rgb=%b want 0/000", o, c); else pass_cnt++;
    probe(192, 191, a, o, c);
    total_cnt++; if (o !== 1'b1) $display("FAIL render_y191: got %b want 1", o); else pass_cnt++;
    probe(192, 192, a, o, c);
    total_cnt++; if (o !== 1'b0) $display("FAIL render_y192: got %b want 0", o); else pass_cnt++;
    probe(196, 128, a, o, c);
    total_cnt++; if (o !== 1'b1 || c !== 3'b000) $display("FAIL render_unlit_bit: got on=%b rgb=%b want 1/000", o, c); else pass_cnt++;
    probe(192, 132, a, o, c);
    total_cnt++; if (a !== 11'h311 || c !== 3'b000) $display("FAIL render_row1: got addr=%h rgb=%b want 311/000", a, c); else pass_cnt++;
  endtask

  task automatic test_snapshot();
    logic [10:0] a; logic o; logic [2:0] c;
    digits = 24'h999999;
    probe(192, 128, a, o, c);
    total_cnt++; if (a !== 11'h310) $display("FAIL snapshot_hold: got %h want 310", a); else pass_cnt++;
    tick();
    probe(192, 128, a, o, c);
    total_cnt++; if (a !== 11'h390) $display("FAIL snapshot_update: got %h want 390", a); else pass_cnt++;
  endtask

  task automatic test_edit_blink();
    logic [10:0] a; logic o; logic [2:0] c;
    reset_dut();
    digits = 24'h563412; edit_sel = 3'b010; alarm = 1'b0;
    repeat (29) tick();
    probe(288, 128, a, o, c);
    total_cnt++; if (c !== 3'b100) $display("FAIL edit_vis_grp1: got %b want 100", c); else pass_cnt++;
    probe(192, 128, a, o, c);
    total_cnt++; if (c !== 3'b111) $display("FAIL edit_vis_grp0: got %b want 111", c); else pass_cnt++;
    tick();
    probe(288, 128, a, o, c);
    total_cnt++; if (o !== 1'b1 || c !== 3'b000) $display("FAIL edit_blank_grp1: got on=%b rgb=%b want 1/000", o, c); else pass_cnt++;
    probe(192, 128, a, o, c);
    total_cnt++; if (c !== 3'b111) $display("FAIL edit_blank_grp0: got %b want 111", c); else pass_cnt++;
    probe(352, 128, a, o, c);
    total_cnt++; if (c !== 3'b111) $display("FAIL edit_sep_noblink: got %b want 111", c); else pass_cnt++;
    repeat (30) tick();
    probe(288, 128, a, o, c);
    total_cnt++; if (c !== 3'b100) $display("FAIL edit_revisible: got %b want 100", c); else pass_cnt++;
  endtask

  task automatic test_alarm();
    logic [10:0] a; logic o; logic [2:0] c;
    reset_dut();
    digits = 24'h563412; edit_sel = 3'b000; alarm = 1'b1;
    tick();
    probe(256, 128, a, o, c);
    total_cnt++; if (c !== 3'b100) $display("FAIL alarm_sep_ph1: got %b want 100", c); else pass_cnt++;
    probe(192, 128, a, o, c);
    total_cnt++; if (c !== 3'b100) $display("FAIL alarm_digit_ph1: got %b want 100", c); else pass_cnt++;
    repeat (29) tick();
    probe(256, 128, a, o, c);
    total_cnt++; if (c !== 3'b111) $display("FAIL alarm_sep_ph0: got %b want 111", c); else pass_cnt++;
    repeat (30) tick();
    probe(192, 128, a, o, c);
    total_cnt++; if (c !== 3'b100) $display("FAIL alarm_digit_ph1b: got %b want 100", c); else pass_cnt++;
  endtask

  task automatic test_invalid_bcd();
    logic [10:0] a; logic o; logic [2:0] c;
    digits = 24'h5634C2; alarm = 1'b0; tick();
    probe(192, 148, a, o, c);
    total_cnt++; if (a !== 11'h3f5) $display("FAIL invalid_bcd: got %h want 3f5", a); else pass_cnt++;
    probe(224, 128, a, o, c);
    total_cnt++; if (a !== 11'h320) $display("FAIL invalid_low_nibble: got %h want 320", a); else pass_cnt++;
    probe(191, 128, a, o, c);
    total_cnt++; if (o !== 1'b0 || c !== 3'b000) $display("FAIL edge_x191: got on=%b rgb=%b want 0/000", o, c); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int x; logic exp_on; logic [2:0] exp_rgb;
    pix_y = 10'd128;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i < 12) pix_x = 10'(188 + i);
      @(posedge clk); #1;
      if (i >= 1) begin
        x = 188 + i - 1;
        exp_on  = (x >= 192);
        exp_rgb = (x >= 192 && x < 196) ? 3'b111 : 3'b000;
        total_cnt++;
        if (text_on !== exp_on || text_rgb !== exp_rgb)
          $display("FAIL stream_x%0d: got on=%b rgb=%b want %b/%b", x, text_on, text_rgb, exp_on, exp_rgb);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_render();
    test_snapshot();
    test_edit_blink();
    test_alarm();
    test_invalid_bcd();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
